freq_range_ctrl: RTL

FREQ_RANGE_CTRL -- requirements
Module: freq_range_ctrl

---
 rtl/freq_range_ctrl.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/freq_range_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// freq_range_ctrl
//
// Gated frequency counter with automatic range selection. An external
// "frequency chooser" either passes sigIn straight through (range 0) or divides
// it by 10 (range 1). This block drives the chooser through rangeSel. It counts
// rising edges of the chosen signal over a fixed gate window, and it may switch
// range once per measurement before latching a result.
//
// Measurement sequence:
//   IDLE -> SETTLE (discard SETTLE_CYCLES) -> GATE (count GATE_CYCLES)
//        -> EVAL (1 cycle: re-range once, or latch the result) -> IDLE
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst_n        asynchronous active-low reset
//   start        request to begin a measurement (acted on only in IDLE)
//   contEn       continuous mode: IDLE immediately starts the next measurement
//   autoEn       1 = automatic range selection, 0 = use manualRange
//   manualRange  range used when autoEn = 0 (0 direct, 1 divide-by-10)
//   sigIn        asynchronous measured signal (output of the chooser)
//   rangeSel     chooser control (1 = divided by 10)
//   freqCount    raw edge count of the last completed measurement
//   freqScaled   freqCount x10 if the result range was 1, else zero-extended
//   resultRange  range in effect for the latched result
//   countValid   one-cycle strobe when the result outputs update
//   overRange    latched result saturated the edge counter
//   busy         high in every state except IDLE
//   stateDbg     current FSM state (IDLE=0, SETTLE=1, GATE=2, EVAL=3)
//
// Handshake: start is sampled on every rising edge. It is honoured only in IDLE
// and ignored elsewhere. There is no ready signal. countValid is a
// single-cycle strobe with no back-pressure. freqCount, freqScaled,
// resultRange and overRange change only in the cycle that countValid is high.
// They then hold until the next strobe.
// -----------------------------------------------------------------------------
module freq_range_ctrl #(
  parameter int unsigned GATE_CYCLES   = 50000000,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 24,
  parameter int unsigned HIGH_THRESH   = 1000000,
  parameter int unsigned LOW_THRESH    = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             contEn,
  input  logic             autoEn,
  input  logic             manualRange,
  input  logic             sigIn,
  output logic             rangeSel,
  output logic [CNT_W-1:0] freqCount,
  output logic [CNT_W+3:0] freqScaled,
  output logic             resultRange,
  output logic             countValid,
  output logic             overRange,
  output logic             busy,
  output logic [1:0]       stateDbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2,
    EVAL   = 2'd3
  } stateE;

  // One timer serves both SETTLE and GATE. It counts 0 .. N-1 within a state.
  localparam int unsigned MAX_CYC = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  stateE             state;
  stateE             stateNext;
  logic [TMR_W-1:0]  tmr;
  logic              settleDone;
  logic              gateDone;
  logic              goStart;

  logic              syncA;
  logic              syncB;
  logic              syncPrev;
  logic              risingEdge;

  logic [CNT_W-1:0]  edgeCnt;
  logic              satFlag;
  logic [31:0]       cntWide;
  logic              reRanged;
  logic              upRange;
  logic              downRange;

  logic              enterFromIdle;
  logic              latchResult;

  logic [CNT_W+3:0]  cntX8;
  logic [CNT_W+3:0]  cntX2;
  logic [CNT_W+3:0]  cntX10;

  // ---------------------------------------------------------------------------
  // Input synchroniser and rising-edge detect on the synchronised signal.
  // syncPrev is a third flop that only holds the previous synchronised value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncA    <= 1'b0;
      syncB    <= 1'b0;
      syncPrev <= 1'b0;
    end else begin
      syncA    <= sigIn;
      syncB    <= syncA;
      syncPrev <= syncB;
    end
  end

  assign risingEdge = syncB & ~syncPrev;

  // ---------------------------------------------------------------------------
  // Range decisions, evaluated only when the FSM is in EVAL.
  // Only one re-range is allowed per measurement, tracked by reRanged.
  // ---------------------------------------------------------------------------
  assign cntWide   = 32'(edgeCnt);
  assign upRange   = autoEn & ~reRanged & ~rangeSel & ((cntWide > HIGH_THRESH) | satFlag);
  assign downRange = autoEn & ~reRanged &  rangeSel &  (cntWide < LOW_THRESH);

  assign goStart    = start | contEn;
  assign settleDone = (tmr == SETTLE_LAST);
  assign gateDone   = (tmr == GATE_LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (goStart)    stateNext = SETTLE;
      SETTLE:  if (settleDone) stateNext = GATE;
      GATE:    if (gateDone)   stateNext = EVAL;
      EVAL:    stateNext = (upRange | downRange) ? SETTLE : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and internal strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    busy          = (state != IDLE);
    stateDbg      = state;
    enterFromIdle = (state == IDLE) & goStart;
    latchResult   = (state == EVAL) & ~(upRange | downRange);
  end

  // ---------------------------------------------------------------------------
  // Phase timer. It restarts at zero on every state change, so each SETTLE
  // (including one after a re-range) lasts exactly SETTLE_CYCLES cycles.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
    end else if (stateNext != state) begin
      tmr <= '0;
    end else if ((state == SETTLE) || (state == GATE)) begin
      tmr <= tmr + 1'b1;
    end else begin
      tmr <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Edge counter. It clears throughout SETTLE and counts only in GATE.
  // An edge that arrives while the counter is full sets satFlag instead of
  // wrapping.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edgeCnt <= '0;
      satFlag <= 1'b0;
    end else if (state == SETTLE) begin
      edgeCnt <= '0;
      satFlag <= 1'b0;
    end else if ((state == GATE) && risingEdge) begin
      if (edgeCnt == CNT_MAX) begin
        satFlag <= 1'b1;
      end else begin
        edgeCnt <= edgeCnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Range selection. A fresh measurement loads manualRange in manual mode.
  // In auto mode it keeps the last range, so a steady input is measured
  // without re-ranging every time.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rangeSel <= 1'b0;
      reRanged <= 1'b0;
    end else if (enterFromIdle) begin
      reRanged <= 1'b0;
      if (!autoEn) begin
        rangeSel <= manualRange;
      end
    end else if (state == EVAL) begin
      if (upRange) begin
        rangeSel <= 1'b1;
        reRanged <= 1'b1;
      end else if (downRange) begin
        rangeSel <= 1'b0;
        reRanged <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // x10 scaling as (count << 3) + (count << 1).
  // (2^CNT_W - 1) * 10 < 2^(CNT_W+4), so this sum cannot overflow.
  // ---------------------------------------------------------------------------
  assign cntX8  = {1'b0, edgeCnt, 3'b000};
  assign cntX2  = {3'b000, edgeCnt, 1'b0};
  assign cntX10 = cntX8 + cntX2;

  // ---------------------------------------------------------------------------
  // Result registers. They load on the EVAL cycle that does not re-range.
  // countValid is high in the cycle after that EVAL cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freqCount   <= '0;
      freqScaled  <= '0;
      resultRange <= 1'b0;
      overRange   <= 1'b0;
      countValid  <= 1'b0;
    end else begin
      countValid <= latchResult;
      if (latchResult) begin
        freqCount   <= edgeCnt;
        freqScaled  <= rangeSel ? cntX10 : {4'b0000, edgeCnt};
        resultRange <= rangeSel;
        overRange   <= satFlag;
      end
    end
  end

endmodule
